// File: rtl/t5_fetch.sv
// Multi-hart instruction fetch unit: one PC per hart, round-robin issue of
// Wishbone classic fetches, per-hart PC redirect from the execute stage.
module t5_fetch #(
    parameter int          NHART    = 4,
    parameter int          HBITS    = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic             sclk,
    input  logic             srst_n,
    input  logic             sena,
    input  logic [NHART-1:0] hart_en,
    output logic [29:0]      iwb_adr,
    output logic             iwb_stb,
    output logic             iwb_wre,
    output logic [3:0]       iwb_sel,
    input  logic             iwb_ack,
    output logic [29:0]      fpc,
    output logic [HBITS-1:0] fhart,
    output logic             fvld,
    input  logic             xvld,
    input  logic [HBITS-1:0] xhart,
    input  logic [1:0]       xbra,
    input  logic [1:0]       xstb,
    input  logic [29:0]      xbpc,
    input  logic [29:0]      xpc,
    input  logic [31:0]      mtvec
);

    logic [29:0]      pc_q [NHART];
    logic [29:0]      pc_d [NHART];
    logic [NHART-1:0] pend_q, pend_d, elig;
    logic [HBITS-1:0] last_q, last_d;
    logic [HBITS-1:0] ihart_q, ihart_d;
    logic [HBITS-1:0] fhart_q, fhart_d;
    logic [HBITS-1:0] gnt, cand;
    logic [29:0]      adr_q, adr_d;
    logic [29:0]      fpc_q, fpc_d;
    logic [29:0]      redir_pc;
    logic             stb_q, stb_d;
    logic             fvld_q, fvld_d;
    logic             gnt_vld, bus_free, ack_fire;
    logic             unused_mtvec_lsbs;

    assign elig     = hart_en & ~pend_q;
    assign bus_free = ~stb_q | iwb_ack;
    assign ack_fire = stb_q & iwb_ack;

    // Walk offsets from farthest to nearest so the hart right after last_q wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        cand    = '0;
        for (int k = NHART; k >= 1; k--) begin
            cand = last_q + HBITS'(k);
            if (elig[cand]) begin
                gnt_vld = 1'b1;
                gnt     = cand;
            end
        end
    end

    always_comb begin
        case ({xbra, &xstb})
            3'b110, 3'b001: redir_pc = mtvec[31:2];
            3'b100:         redir_pc = xbpc;
            default:        redir_pc = xpc;
        endcase
    end

    always_comb begin
        pc_d    = pc_q;
        pend_d  = pend_q;
        last_d  = last_q;
        adr_d   = adr_q;
        stb_d   = stb_q;
        ihart_d = ihart_q;
        fpc_d   = fpc_q;
        fhart_d = fhart_q;
        fvld_d  = fvld_q;
        if (sena) begin
            fvld_d = ack_fire;
            if (ack_fire) begin
                fpc_d   = adr_q;
                fhart_d = ihart_q;
            end
            if (bus_free) begin
                if (gnt_vld) begin
                    adr_d        = pc_q[gnt];
                    stb_d        = 1'b1;
                    ihart_d      = gnt;
                    pend_d[gnt]  = 1'b1;
                    last_d       = gnt;
                end else begin
                    stb_d = 1'b0;
                end
            end
            // Applied after the grant so a retire always clears pend.
            if (xvld) begin
                pend_d[xhart] = 1'b0;
                pc_d[xhart]   = redir_pc;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NHART; gi++) begin : g_pc
            always_ff @(posedge sclk or negedge srst_n) begin
                if (!srst_n) pc_q[gi] <= RESET_PC[31:2];
                else         pc_q[gi] <= pc_d[gi];
            end
        end
    endgenerate

    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            pend_q  <= '0;
            last_q  <= HBITS'(NHART - 1);
            adr_q   <= '0;
            stb_q   <= 1'b0;
            ihart_q <= '0;
            fpc_q   <= '0;
            fhart_q <= '0;
            fvld_q  <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            last_q  <= last_d;
            adr_q   <= adr_d;
            stb_q   <= stb_d;
            ihart_q <= ihart_d;
            fpc_q   <= fpc_d;
            fhart_q <= fhart_d;
            fvld_q  <= fvld_d;
        end
    end

    assign iwb_adr = adr_q;
    assign iwb_stb = stb_q;
    assign iwb_wre = 1'b0;
    assign iwb_sel = 4'hF;
    assign fpc     = fpc_q;
    assign fhart   = fhart_q;
    assign fvld    = fvld_q;

    assign unused_mtvec_lsbs = &{1'b0, mtvec[1:0]};

endmodule

// File: tb/tb_t5_fetch.sv
// Bench for t5_fetch: bus and execute-stage responders, a transaction-level
// reference model compared every cycle, and directed scenario checks.
module tb_t5_fetch;
    localparam int          NH    = 4;
    localparam int          HB    = 2;
    localparam logic [31:0] RPC   = 32'h100;
    localparam logic [29:0] RPC_W = 30'(RPC >> 2);

    logic          sclk, srst_n, sena;
    logic [NH-1:0] hart_en;
    logic [29:0]   iwb_adr;
    logic          iwb_stb, iwb_wre, iwb_ack;
    logic [3:0]    iwb_sel;
    logic [29:0]   fpc;
    logic [HB-1:0] fhart;
    logic          fvld, xvld;
    logic [HB-1:0] xhart;
    logic [1:0]    xbra, xstb;
    logic [29:0]   xbpc, xpc;
    logic [31:0]   mtvec;

    t5_fetch #(.NHART(NH), .HBITS(HB), .RESET_PC(RPC)) dut (
        .sclk(sclk), .srst_n(srst_n), .sena(sena), .hart_en(hart_en),
        .iwb_adr(iwb_adr), .iwb_stb(iwb_stb), .iwb_wre(iwb_wre), .iwb_sel(iwb_sel),
        .iwb_ack(iwb_ack), .fpc(fpc), .fhart(fhart), .fvld(fvld),
        .xvld(xvld), .xhart(xhart), .xbra(xbra), .xstb(xstb),
        .xbpc(xbpc), .xpc(xpc), .mtvec(mtvec)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [29:0] m_pc [NH];
    bit          m_pend [NH];
    int          m_last, m_ih, m_fh, m_g;
    bit          m_stb, m_fvld, m_fire;
    logic [29:0] m_adr, m_fpc;

    function automatic logic [29:0] target(input logic [1:0] b, input logic [1:0] s,
                                           input logic [29:0] bpc, input logic [29:0] seq,
                                           input logic [31:0] tv);
        bit both = (s == 2'b11);
        if ((b == 2'b11 && !both) || (b == 2'b00 && both)) return tv[31:2];
        if (b == 2'b10 && !both) return bpc;
        return seq;
    endfunction

    always @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            for (int h = 0; h < NH; h++) begin
                m_pc[h]   = RPC_W;
                m_pend[h] = 1'b0;
            end
            m_last = NH - 1; m_stb = 0; m_adr = '0; m_ih = 0;
            m_fvld = 0; m_fpc = '0; m_fh = 0;
        end else if (sena) begin
            m_fire = m_stb && iwb_ack;
            m_g = -1;
            for (int s = 1; s <= NH; s++)
                if (m_g < 0 && hart_en[(m_last + s) % NH] && !m_pend[(m_last + s) % NH])
                    m_g = (m_last + s) % NH;
            if (m_fire) begin
                m_fpc = m_adr;
                m_fh  = m_ih;
            end
            m_fvld = m_fire;
            if (!m_stb || iwb_ack) begin
                if (m_g >= 0) begin
                    m_adr = m_pc[m_g]; m_stb = 1; m_ih = m_g;
                    m_pend[m_g] = 1; m_last = m_g;
                end else begin
                    m_stb = 0;
                end
            end
            if (xvld) begin
                m_pend[xhart] = 0;
                m_pc[xhart]   = target(xbra, xstb, xbpc, xpc, mtvec);
            end
        end
    end

    always @(negedge sclk) begin
        check("iwb_stb", iwb_stb, m_stb);
        check("iwb_adr", iwb_adr, m_adr);
        check("fvld", fvld, m_fvld);
        check("fpc", fpc, m_fpc);
        check("fhart", fhart, m_fh);
        check("iwb_wre", iwb_wre, 0);
        check("iwb_sel", iwb_sel, 4'hF);
    end

    // ---------------- bus and execute responders ----------------
    typedef struct {int h; logic [29:0] pc; int due;} ret_t;
    ret_t rq[$];
    ret_t r;
    int   cyc = 0, wcnt = 0, wait_n = 0, x_delay = 3;
    bit   rand_mode = 0;
    int   ovr [NH];

    always @(posedge sclk) begin
        #1;
        cyc++;
        if (!srst_n) begin
            rq.delete(); wcnt = 0; iwb_ack = 0; xvld = 0;
        end else begin
            if (sena && fvld)
                rq.push_back('{int'(fhart), fpc, cyc + (rand_mode ? int'($urandom_range(1, 6)) : x_delay)});
            sena = rand_mode ? ($urandom % 8 != 0) : 1'b1;
            iwb_ack = 0;
            if (sena && iwb_stb) begin
                if (rand_mode) iwb_ack = ($urandom % 3 == 0);
                else if (wcnt >= wait_n) begin iwb_ack = 1; wcnt = 0; end
                else wcnt++;
            end
            xvld = 0; xbra = 0; xstb = 0;
            xbpc = 30'($urandom); mtvec = $urandom;
            if (sena) begin
                if (rq.size() > 0 && rq[0].due <= cyc) begin
                    r = rq.pop_front();
                    xvld = 1; xhart = HB'(r.h); xpc = r.pc + 30'd1;
                    case (ovr[r.h])
                        1: begin xbra = 2'b10; xstb = 2'b00; xbpc = 30'h800; end
                        2: begin xbra = 2'b11; xstb = 2'b00; mtvec = 32'h80; end
                        3: begin xbra = 2'b00; xstb = 2'b11; mtvec = 32'h80; end
                        default: if (rand_mode) begin
                            xbra = 2'($urandom); xstb = 2'($urandom);
                            if ($urandom % 4 == 0) xpc = 30'($urandom);
                        end
                    endcase
                    ovr[r.h] = 0;
                end else if (rand_mode && $urandom % 20 == 0) begin
                    xvld = 1; xhart = HB'($urandom_range(0, NH - 1));
                    xpc = 30'($urandom); xbra = 2'($urandom); xstb = 2'($urandom);
                end
            end
        end
    end

    task automatic get_fetch(input int want, output int h, output logic [29:0] p);
        h = -1; p = '0;
        for (int t = 0; t < 300; t++) begin
            @(negedge sclk);
            if (fvld && (want < 0 || int'(fhart) == want)) begin
                h = int'(fhart); p = fpc;
                return;
            end
        end
        n_cmp++; n_bad++;
        $display("FAIL fetch_timeout hart %0d: got none expected a fetch", want);
    endtask

    int          h, prev, cnt;
    logic [29:0] p, p2, a0;
    bit          pstb, pack, found;

    initial begin
        for (int i = 0; i < NH; i++) ovr[i] = 0;
        sena = 1; hart_en = '0; iwb_ack = 0; xvld = 0; xhart = '0;
        xbra = 0; xstb = 0; xbpc = '0; xpc = '0; mtvec = '0; srst_n = 0;
        repeat (3) @(negedge sclk);
        check("rst_stb", iwb_stb, 0);
        check("rst_fvld", fvld, 0);
        check("rst_adr", iwb_adr, 0);
        hart_en = 4'hF; srst_n = 1;

        // round-robin start-up, next fetch at PC+4
        for (int i = 0; i < 8; i++) begin
            get_fetch(-1, h, p);
            check("t1_hart", h, i % 4);
            check("t1_pc", p, (i < 4) ? RPC_W : RPC_W + 30'd1);
        end

        // three wait states hold the bus
        wait_n = 3;
        @(negedge sclk);
        pstb = iwb_stb; pack = iwb_ack; found = 0;
        for (int t = 0; t < 100 && !found; t++) begin
            @(negedge sclk);
            if (iwb_stb && (!pstb || pack)) found = 1;
            pstb = iwb_stb; pack = iwb_ack;
        end
        check("t2_found", found, 1);
        a0 = iwb_adr;
        for (int k = 1; k <= 3; k++) begin
            @(negedge sclk);
            check("t2_stb_hold", iwb_stb, 1);
            check("t2_adr_hold", iwb_adr, a0);
            check("t2_no_fvld", fvld, 0);
        end
        @(negedge sclk);
        check("t2_fvld", fvld, 1);
        check("t2_fpc", fpc, a0);
        wait_n = 0;

        // branch and both misaligned-trap encodings on hart 2
        for (int k = 1; k <= 3; k++) begin
            ovr[2] = k;
            for (int t = 0; t < 300 && ovr[2] != 0; t++) @(negedge sclk);
            get_fetch(2, h, p);
            check("t34_redirect_pc", p, (k == 1) ? 30'h800 : 30'h20);
        end

        // harts 0 and 2 only, then park hart 2 mid-flight
        hart_en = 4'b0101;
        repeat (20) @(negedge sclk);
        get_fetch(-1, prev, p);
        check("t5_hart_set", (prev == 0 || prev == 2), 1);
        for (int i = 0; i < 5; i++) begin
            get_fetch(-1, h, p);
            check("t5_order", h, (prev == 0) ? 2 : 0);
            prev = h;
        end
        get_fetch(2, h, p2);
        hart_en = 4'b0001;
        cnt = 0;
        repeat (40) begin
            @(negedge sclk);
            if (fvld && fhart == 2) cnt++;
        end
        check("t5_parked", cnt, 0);
        hart_en = 4'b0101;
        get_fetch(2, h, p);
        check("t5_resume_pc", p, p2 + 30'd1);

        // randomized traffic
        rand_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge sclk);
            if (i % 64 == 0) hart_en = NH'($urandom);
        end
        rand_mode = 0; hart_en = 4'hF;
        repeat (4) @(negedge sclk);

        // asynchronous reset in the middle of a bus cycle
        wait_n = 3; found = 0;
        for (int t = 0; t < 200 && !found; t++) begin
            @(negedge sclk);
            if (iwb_stb && !iwb_ack) found = 1;
        end
        check("t6_found", found, 1);
        #2 srst_n = 0;
        #1;
        check("t6_stb", iwb_stb, 0);
        check("t6_fvld", fvld, 0);
        check("t6_adr", iwb_adr, 0);
        repeat (2) @(negedge sclk);
        wait_n = 0; srst_n = 1;
        for (int i = 0; i < 4; i++) begin
            get_fetch(-1, h, p);
            check("t6_hart", h, i);
            check("t6_pc", p, RPC_W);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1);
    end
endmodule

// File: doc/t5_fetch.md
# t5_fetch

Parametrised multi-hart instruction fetch unit for the t5 core. It keeps one program counter per hardware thread (hart) and issues instruction fetches to the Wishbone instruction bus from a round-robin scheduler. Only enabled harts with no instruction already in flight are scheduled. It honours bus wait states via `iwb_ack` and accepts per-hart PC redirects (PC+4, branch, misalignment trap) from the execute stage. It sits between the execute stage's PC write-back and the decode stage.

## Interface
- `NHART`, 4: number of harts; power of two, 2..16.
- `HBITS`, 2: hart index width, equal to log2(NHART).
- `RESET_PC`, 32'h0: reset value of every hart PC; bits [1:0] are ignored.

Ports:
- `sclk` in 1: the one clock; all state changes on its rising edge.
- `srst_n` in 1: asynchronous, active-low reset.
- `sena` in 1: pipeline enable; all registers hold when low.
- `hart_en` in NHART: per-hart run enable; bit h=0 parks hart h.
- `iwb_adr` out 30: fetch word address [31:2].
- `iwb_stb` out 1: fetch request strobe.
- `iwb_wre` out 1: constant 0.
- `iwb_sel` out 4: constant 4'hF.
- `iwb_ack` in 1: fetch complete.
- `fpc` out 30: address [31:2] of the fetched instruction.
- `fhart` out HBITS: hart that owns `fpc`.
- `fvld` out 1: one-cycle pulse; `fpc`/`fhart` are valid.
- `xvld` in 1: the execute stage retires one instruction of hart `xhart`.
- `xhart` in HBITS: retiring hart.
- `xbra` in 2: branch status of the retiring instruction.
- `xstb` in 2: data-access strobe status of the retiring instruction.
- `xbpc` in 30: branch target [31:2].
- `xpc` in 30: sequential PC (PC+4) [31:2].
- `mtvec` in 32: trap vector; bits [31:2] are used.

## Operation
- State:
  - `pc[NHART]` (30b each)
  - `pend[NHART]`: fetch outstanding / not yet retired
  - `last`: last granted hart, HBITS wide
  - `iwb_adr`, `iwb_stb`, `ihart` (hart owning the current bus cycle)
  - `fpc`, `fhart`, `fvld`
- Eligibility: `elig[h] = hart_en[h] & ~pend[h]`, using registered `pend`.
- Grant rule: pick the first eligible hart in circular order `last+1, last+2, …, last` (wraps modulo NHART). If no hart is eligible, there is no grant.
- Bus free when `~iwb_stb | iwb_ack`.
- With `sena=1`, the bus free, and a grant to hart g:
  - `iwb_adr <= pc[g]`, `iwb_stb <= 1`, `ihart <= g`
  - `pend[g] <= 1`, `last <= g`
- Bus free and no grant: `iwb_stb <= 0`.
- Bus busy (`iwb_stb & ~iwb_ack`): `iwb_adr`, `iwb_stb` and `ihart` hold (Wishbone classic rule).
- On `iwb_ack` while `iwb_stb=1` (and `sena=1`):
  - `fpc <= iwb_adr`, `fhart <= ihart`, `fvld <= 1`
  - otherwise `fvld <= 0`
- Redirect on `xvld` (with `sena=1`): `pend[xhart] <= 0`, and `pc[xhart]` is loaded according to `{xbra, &xstb}`:
  - 3'b110 or 3'b001: `mtvec[31:2]` (misaligned trap)
  - 3'b100: `xbpc`
  - all other values: `xpc`
- `xvld` for a hart whose `pend` is 0: the PC is still updated and `pend` stays 0.
- Same-edge `xvld` for hart h and a grant of hart h: cannot occur, because `pend[h]=1` blocks the grant. The `pend` clear always wins.
- Parking a hart: dropping `hart_en[h]` while `pend[h]=1` lets the in-flight fetch and retire complete. The hart is not regranted until re-enabled, and its PC is preserved.
- `sena=0`: all state frozen, including bus hold. The bus must not assert `iwb_ack` while `sena=0` (system contract).
- Reset (async, any time, including mid bus cycle):
  - `pc[*] = RESET_PC[31:2]`, `pend = 0`, `last = NHART-1` (so hart 0 is granted first)
  - `iwb_stb = 0`, `iwb_adr = 0`, `ihart = 0`
  - `fpc = 0`, `fhart = 0`, `fvld = 0`
  - Outstanding fetches are abandoned.

## Timing
- Grant → `iwb_stb`/`iwb_adr` visible: 1 cycle (registered).
- `iwb_ack` → `fvld`/`fpc`/`fhart`: 1 cycle (registered).
- Zero-wait bus: the ack cycle also issues the next grant, giving one fetch per cycle sustained.
- `xvld` → hart eligible: the next cycle. Earliest re-fetch of hart h: the edge after its `pend` clears.
- Single-hart throughput equals the fetch-to-retire loop. With all NHART harts enabled and a loop ≤ NHART cycles, the bus never idles.

## Test plan
1. Reset, NHART=4, `RESET_PC`=0x100, `hart_en`=4'hF, `iwb_ack` tied 1, `xvld` returns `xpc`=`pc`+4 three cycles after `fvld` → `iwb_adr`×4 sequence 0x100 for harts 0,1,2,3. Each hart's next fetch is at 0x104; `fhart` cycles 0,1,2,3,0.
2. `iwb_ack` delayed 3 cycles → `iwb_adr`/`iwb_stb` stable for 3 cycles; exactly one `fvld` pulse; no grant during the wait.
3. `xvld`, `xhart`=2, `xbra`=2'b10, `xstb`=0, `xbpc`=0x2000>>2 → the next hart-2 fetch is at 0x2000; other harts are unaffected.
4. `xbra`=2'b11, `xstb`=2'b00, `mtvec`=0x80 → the next fetch is at 0x80. Repeat with `xbra`=0, `xstb`=2'b11 → 0x80.
5. `hart_en`=4'b0101 → the grant order is 0,2,0,2. Clear bit 2 while hart 2 is pending → its fetch and retire complete, and hart 2 is never regranted until re-enabled.
6. Assert `srst_n`=0 asynchronously mid-bus-cycle with `iwb_stb`=1 → `iwb_stb`, `fvld` and `pend` clear immediately. After release, the first grant is hart 0 at `RESET_PC`.
